// File: rtl/mem_access.sv
// MEM-stage load/store unit and MEM/WB register: issues data-bus accesses over a req/ack
// handshake, stalls upstream while one is outstanding, and registers the write-back result.
module mem_access #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [4:0]        mem_wd,
  input  logic              mem_wreg,
  input  logic [DATA_W-1:0] mem_wdata,
  input  logic [7:0]        mem_aluop,
  input  logic [ADDR_W-1:0] mem_mem_addr,
  input  logic [DATA_W-1:0] mem_reg2,
  input  logic [31:0]       mem_pc,
  input  logic [DATA_W-1:0] dbus_rdata,
  input  logic              dbus_ack,
  output logic              dbus_req,
  output logic              dbus_we,
  output logic [ADDR_W-1:0] dbus_addr,
  output logic [3:0]        dbus_sel,
  output logic [DATA_W-1:0] dbus_wdata,
  output logic              stallreq,
  output logic [4:0]        wb_wd,
  output logic              wb_wreg,
  output logic [DATA_W-1:0] wb_wdata,
  output logic [31:0]       wb_pc,
  output logic              exc_adel,
  output logic              exc_ades,
  output logic [ADDR_W-1:0] badvaddr
);

  localparam logic [7:0] OpLb  = 8'hE0;
  localparam logic [7:0] OpLbu = 8'hE4;
  localparam logic [7:0] OpLh  = 8'hE1;
  localparam logic [7:0] OpLhu = 8'hE5;
  localparam logic [7:0] OpLw  = 8'hE3;
  localparam logic [7:0] OpSb  = 8'hE8;
  localparam logic [7:0] OpSh  = 8'hE9;
  localparam logic [7:0] OpSw  = 8'hEB;

  typedef enum logic [1:0] {StIdle, StBusy, StDone} state_e;

  state_e            state_q, state_d;
  logic              dbus_req_q, dbus_req_d, dbus_we_q, dbus_we_d;
  logic [ADDR_W-1:0] dbus_addr_q, dbus_addr_d, badvaddr_q, badvaddr_d;
  logic [3:0]        dbus_sel_q, dbus_sel_d;
  logic [DATA_W-1:0] dbus_wdata_q, dbus_wdata_d, wb_wdata_q, wb_wdata_d;
  logic [4:0]        wb_wd_q, wb_wd_d, lat_wd_q, lat_wd_d;
  logic              wb_wreg_q, wb_wreg_d, lat_wreg_q, lat_wreg_d;
  logic [31:0]       wb_pc_q, wb_pc_d, lat_pc_q, lat_pc_d;
  logic [7:0]        lat_aluop_q, lat_aluop_d;
  logic [1:0]        lat_off_q, lat_off_d;
  logic              exc_adel_q, exc_adel_d, exc_ades_q, exc_ades_d;

  logic       is_load, is_store, misaligned, lat_store;
  logic [1:0] off;
  logic [7:0] rd_byte;
  logic [15:0] rd_half;
  logic [DATA_W-1:0] load_data;

  assign off        = mem_mem_addr[1:0];
  assign is_load    = (mem_aluop == OpLb) || (mem_aluop == OpLbu) || (mem_aluop == OpLh) ||
                      (mem_aluop == OpLhu) || (mem_aluop == OpLw);
  assign is_store   = (mem_aluop == OpSb) || (mem_aluop == OpSh) || (mem_aluop == OpSw);
  assign misaligned = (((mem_aluop == OpLh) || (mem_aluop == OpLhu) || (mem_aluop == OpSh)) &&
                       off[0]) ||
                      (((mem_aluop == OpLw) || (mem_aluop == OpSw)) && (off != 2'b00));
  assign lat_store  = (lat_aluop_q == OpSb) || (lat_aluop_q == OpSh) || (lat_aluop_q == OpSw);

  // Lane select for the returning load uses the offset captured at issue.
  always_comb begin
    rd_byte   = dbus_rdata[7:0];
    rd_half   = dbus_rdata[15:0];
    load_data = dbus_rdata;
    unique case (lat_off_q)
      2'd0: rd_byte = dbus_rdata[7:0];
      2'd1: rd_byte = dbus_rdata[15:8];
      2'd2: rd_byte = dbus_rdata[23:16];
      2'd3: rd_byte = dbus_rdata[31:24];
      default: rd_byte = dbus_rdata[7:0];
    endcase
    if (lat_off_q[1]) rd_half = dbus_rdata[31:16];
    case (lat_aluop_q)
      OpLb:    load_data = {{24{rd_byte[7]}}, rd_byte};
      OpLbu:   load_data = {24'd0, rd_byte};
      OpLh:    load_data = {{16{rd_half[15]}}, rd_half};
      OpLhu:   load_data = {16'd0, rd_half};
      default: load_data = dbus_rdata;
    endcase
  end

  always_comb begin
    state_d      = state_q;
    dbus_req_d   = dbus_req_q;
    dbus_we_d    = dbus_we_q;
    dbus_addr_d  = dbus_addr_q;
    dbus_sel_d   = dbus_sel_q;
    dbus_wdata_d = dbus_wdata_q;
    wb_wd_d      = wb_wd_q;
    wb_wreg_d    = wb_wreg_q;
    wb_wdata_d   = wb_wdata_q;
    wb_pc_d      = wb_pc_q;
    lat_wd_d     = lat_wd_q;
    lat_wreg_d   = lat_wreg_q;
    lat_pc_d     = lat_pc_q;
    lat_aluop_d  = lat_aluop_q;
    lat_off_d    = lat_off_q;
    badvaddr_d   = badvaddr_q;
    exc_adel_d   = 1'b0;
    exc_ades_d   = 1'b0;
    stallreq     = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (!(is_load || is_store)) begin
          wb_wd_d    = mem_wd;
          wb_wreg_d  = mem_wreg;
          wb_wdata_d = mem_wdata;
          wb_pc_d    = mem_pc;
        end else if (misaligned) begin
          exc_adel_d = is_load;
          exc_ades_d = is_store;
          badvaddr_d = mem_mem_addr;
          wb_wreg_d  = 1'b0;
        end else begin
          stallreq    = 1'b1;
          lat_wd_d    = mem_wd;
          lat_wreg_d  = mem_wreg;
          lat_pc_d    = mem_pc;
          lat_aluop_d = mem_aluop;
          lat_off_d   = off;
          dbus_req_d  = 1'b1;
          dbus_we_d   = is_store;
          dbus_addr_d = {mem_mem_addr[ADDR_W-1:2], 2'b00};
          if ((mem_aluop == OpLb) || (mem_aluop == OpLbu) || (mem_aluop == OpSb)) begin
            dbus_sel_d = 4'b0001 << off;
          end else if ((mem_aluop == OpLh) || (mem_aluop == OpLhu) || (mem_aluop == OpSh)) begin
            dbus_sel_d = 4'b0011 << off;
          end else begin
            dbus_sel_d = 4'b1111;
          end
          if (mem_aluop == OpSb)      dbus_wdata_d = {4{mem_reg2[7:0]}};
          else if (mem_aluop == OpSh) dbus_wdata_d = {2{mem_reg2[15:0]}};
          else                        dbus_wdata_d = mem_reg2;
          wb_wreg_d = 1'b0;
          state_d   = StBusy;
        end
      end
      StBusy: begin
        stallreq = 1'b1;
        if (dbus_ack) begin
          dbus_req_d = 1'b0;
          wb_wd_d    = lat_wd_q;
          wb_pc_d    = lat_pc_q;
          wb_wreg_d  = lat_wreg_q & ~lat_store;
          if (!lat_store) wb_wdata_d = load_data;
          state_d    = StDone;
        end
      end
      StDone: begin
        wb_wreg_d = 1'b0;
        state_d   = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= StIdle;
      dbus_req_q   <= 1'b0;
      dbus_we_q    <= 1'b0;
      dbus_addr_q  <= '0;
      dbus_sel_q   <= '0;
      dbus_wdata_q <= '0;
      wb_wd_q      <= '0;
      wb_wreg_q    <= 1'b0;
      wb_wdata_q   <= '0;
      wb_pc_q      <= '0;
      lat_wd_q     <= '0;
      lat_wreg_q   <= 1'b0;
      lat_pc_q     <= '0;
      lat_aluop_q  <= '0;
      lat_off_q    <= '0;
      badvaddr_q   <= '0;
      exc_adel_q   <= 1'b0;
      exc_ades_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      dbus_req_q   <= dbus_req_d;
      dbus_we_q    <= dbus_we_d;
      dbus_addr_q  <= dbus_addr_d;
      dbus_sel_q   <= dbus_sel_d;
      dbus_wdata_q <= dbus_wdata_d;
      wb_wd_q      <= wb_wd_d;
      wb_wreg_q    <= wb_wreg_d;
      wb_wdata_q   <= wb_wdata_d;
      wb_pc_q      <= wb_pc_d;
      lat_wd_q     <= lat_wd_d;
      lat_wreg_q   <= lat_wreg_d;
      lat_pc_q     <= lat_pc_d;
      lat_aluop_q  <= lat_aluop_d;
      lat_off_q    <= lat_off_d;
      badvaddr_q   <= badvaddr_d;
      exc_adel_q   <= exc_adel_d;
      exc_ades_q   <= exc_ades_d;
    end
  end

  assign dbus_req   = dbus_req_q;
  assign dbus_we    = dbus_we_q;
  assign dbus_addr  = dbus_addr_q;
  assign dbus_sel   = dbus_sel_q;
  assign dbus_wdata = dbus_wdata_q;
  assign wb_wd      = wb_wd_q;
  assign wb_wreg    = wb_wreg_q;
  assign wb_wdata   = wb_wdata_q;
  assign wb_pc      = wb_pc_q;
  assign exc_adel   = exc_adel_q;
  assign exc_ades   = exc_ades_q;
  assign badvaddr   = badvaddr_q;

endmodule

// File: tb/tb_mem_access.sv
// Directed testbench for mem_access: ALU pass-through, loads, stores, misalignment, reset abort.
module tb_mem_access;

  logic        clk = 1'b0;
  logic        rst;
  logic [4:0]  mem_wd;
  logic        mem_wreg;
  logic [31:0] mem_wdata, mem_mem_addr, mem_reg2, mem_pc, dbus_rdata;
  logic [7:0]  mem_aluop;
  logic        dbus_ack;
  logic        dbus_req, dbus_we, stallreq, wb_wreg, exc_adel, exc_ades;
  logic [31:0] dbus_addr, dbus_wdata, wb_wdata, wb_pc, badvaddr;
  logic [3:0]  dbus_sel;
  logic [4:0]  wb_wd;

  int vectors = 0;
  int miscompares = 0;

  mem_access #(.ADDR_W(32), .DATA_W(32)) dut (
    .clk(clk), .rst(rst),
    .mem_wd(mem_wd), .mem_wreg(mem_wreg), .mem_wdata(mem_wdata), .mem_aluop(mem_aluop),
    .mem_mem_addr(mem_mem_addr), .mem_reg2(mem_reg2), .mem_pc(mem_pc),
    .dbus_rdata(dbus_rdata), .dbus_ack(dbus_ack),
    .dbus_req(dbus_req), .dbus_we(dbus_we), .dbus_addr(dbus_addr), .dbus_sel(dbus_sel),
    .dbus_wdata(dbus_wdata), .stallreq(stallreq),
    .wb_wd(wb_wd), .wb_wreg(wb_wreg), .wb_wdata(wb_wdata), .wb_pc(wb_pc),
    .exc_adel(exc_adel), .exc_ades(exc_ades), .badvaddr(badvaddr)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [7:0] op, input logic [31:0] addr, input logic [4:0] wd,
                       input logic wreg, input logic [31:0] wdata, input logic [31:0] reg2,
                       input logic [31:0] pc);
    mem_aluop = op; mem_mem_addr = addr; mem_wd = wd; mem_wreg = wreg;
    mem_wdata = wdata; mem_reg2 = reg2; mem_pc = pc;
  endtask

  task automatic nop();
    drive(8'h00, 32'h0, 5'd0, 1'b0, 32'h0, 32'h0, 32'h0);
  endtask

  initial begin
    rst = 1'b1; dbus_ack = 1'b0; dbus_rdata = 32'h0;
    nop();
    tick(); tick();
    rst = 1'b0;
    chk("rst_req", {31'd0, dbus_req}, 32'd0);
    chk("rst_wreg", {31'd0, wb_wreg}, 32'd0);
    chk("rst_wdata", wb_wdata, 32'd0);
    chk("rst_stall", {31'd0, stallreq}, 32'd0);
    chk("rst_exc", {30'd0, exc_adel, exc_ades}, 32'd0);

    // 1: ALU op passes through with one cycle of latency
    drive(8'h21, 32'h0, 5'd5, 1'b1, 32'h1234, 32'h0, 32'h80);
    #1 chk("addu_stall0", {31'd0, stallreq}, 32'd0);
    tick();
    chk("addu_wd", {27'd0, wb_wd}, 32'd5);
    chk("addu_wreg", {31'd0, wb_wreg}, 32'd1);
    chk("addu_wdata", wb_wdata, 32'h1234);
    chk("addu_pc", wb_pc, 32'h80);
    chk("addu_stall1", {31'd0, stallreq}, 32'd0);
    nop();

    // 2: LB at 0x103, ack after 3 busy cycles
    drive(8'hE0, 32'h103, 5'd7, 1'b1, 32'h0, 32'h0, 32'h400);
    #1 chk("lb_stall_idle", {31'd0, stallreq}, 32'd1);
    chk("lb_noreq_idle", {31'd0, dbus_req}, 32'd0);
    tick();
    chk("lb_req", {31'd0, dbus_req}, 32'd1);
    chk("lb_addr", dbus_addr, 32'h100);
    chk("lb_sel", {28'd0, dbus_sel}, 32'h8);
    chk("lb_we", {31'd0, dbus_we}, 32'd0);
    chk("lb_bubble", {31'd0, wb_wreg}, 32'd0);
    tick();
    chk("lb_stall_b2", {31'd0, stallreq}, 32'd1);
    chk("lb_hold_addr", dbus_addr, 32'h100);
    tick();
    chk("lb_stall_b3", {31'd0, stallreq}, 32'd1);
    dbus_ack = 1'b1; dbus_rdata = 32'h8000_0000;
    #1 chk("lb_stall_ack", {31'd0, stallreq}, 32'd1);
    tick();
    dbus_ack = 1'b0;
    chk("lb_req_done", {31'd0, dbus_req}, 32'd0);
    chk("lb_wdata", wb_wdata, 32'hFFFF_FF80);
    chk("lb_wreg", {31'd0, wb_wreg}, 32'd1);
    chk("lb_wd", {27'd0, wb_wd}, 32'd7);
    chk("lb_pc", wb_pc, 32'h400);
    chk("lb_stall_done", {31'd0, stallreq}, 32'd0);
    tick();
    chk("lb_wreg_off", {31'd0, wb_wreg}, 32'd0);
    chk("lb_req_off", {31'd0, dbus_req}, 32'd0);
    nop();

    // 3: LHU at 0x202, zero-wait ack
    drive(8'hE5, 32'h202, 5'd3, 1'b1, 32'h0, 32'h0, 32'h500);
    #1 chk("lhu_stall_idle", {31'd0, stallreq}, 32'd1);
    tick();
    chk("lhu_sel", {28'd0, dbus_sel}, 32'hC);
    chk("lhu_stall_busy", {31'd0, stallreq}, 32'd1);
    dbus_ack = 1'b1; dbus_rdata = 32'hBEEF_0000;
    tick();
    dbus_ack = 1'b0;
    chk("lhu_wdata", wb_wdata, 32'h0000_BEEF);
    chk("lhu_wreg", {31'd0, wb_wreg}, 32'd1);
    chk("lhu_stall_done", {31'd0, stallreq}, 32'd0);
    nop();
    tick();

    // 4: SH at 0x1002 with wreg asserted; store must not write back
    drive(8'hE9, 32'h1002, 5'd9, 1'b1, 32'h0, 32'hAAAA_5A5A, 32'h600);
    tick();
    chk("sh_we", {31'd0, dbus_we}, 32'd1);
    chk("sh_sel", {28'd0, dbus_sel}, 32'hC);
    chk("sh_wdata", dbus_wdata, 32'h5A5A_5A5A);
    chk("sh_addr", dbus_addr, 32'h1000);
    dbus_ack = 1'b1;
    tick();
    dbus_ack = 1'b0;
    chk("sh_wreg", {31'd0, wb_wreg}, 32'd0);
    chk("sh_req_done", {31'd0, dbus_req}, 32'd0);
    nop();
    tick();

    // 5: misaligned LW, then misaligned SW
    drive(8'hE3, 32'h105, 5'd4, 1'b1, 32'h0, 32'h0, 32'h700);
    #1 chk("lw_mis_stall", {31'd0, stallreq}, 32'd0);
    tick();
    chk("lw_mis_req", {31'd0, dbus_req}, 32'd0);
    chk("lw_mis_adel", {31'd0, exc_adel}, 32'd1);
    chk("lw_mis_ades", {31'd0, exc_ades}, 32'd0);
    chk("lw_mis_bad", badvaddr, 32'h105);
    chk("lw_mis_wreg", {31'd0, wb_wreg}, 32'd0);
    drive(8'hEB, 32'h102, 5'd0, 1'b0, 32'h0, 32'h1, 32'h704);
    tick();
    chk("sw_mis_ades", {31'd0, exc_ades}, 32'd1);
    chk("sw_mis_adel", {31'd0, exc_adel}, 32'd0);
    chk("sw_mis_bad", badvaddr, 32'h102);
    chk("sw_mis_req", {31'd0, dbus_req}, 32'd0);
    nop();
    tick();
    chk("exc_clear", {30'd0, exc_adel, exc_ades}, 32'd0);

    // 6: SW aborted by reset while busy; a late ack is ignored
    drive(8'hEB, 32'h300, 5'd0, 1'b0, 32'h0, 32'hCAFE_F00D, 32'h800);
    tick();
    chk("sw_req", {31'd0, dbus_req}, 32'd1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    nop();
    #1 chk("abort_req", {31'd0, dbus_req}, 32'd0);
    chk("abort_stall", {31'd0, stallreq}, 32'd0);
    chk("abort_wb", {wb_wd, wb_wreg} | wb_wdata | wb_pc, 32'd0);
    dbus_ack = 1'b1; dbus_rdata = 32'h1234_5678;
    tick();
    dbus_ack = 1'b0;
    chk("late_ack_wreg", {31'd0, wb_wreg}, 32'd0);
    chk("late_ack_req", {31'd0, dbus_req}, 32'd0);
    chk("late_ack_stall", {31'd0, stallreq}, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
